// File: rtl/bram_pkg.sv
// Shared widths, default frame geometry, arbiter state encoding and {y,x} address packing
// for the frame BRAM port arbiter.
package bram_pkg;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 9;

    localparam int unsigned H_ACTIVE_DFLT = 640;
    localparam int unsigned V_ACTIVE_DFLT = 480;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } arb_state_e;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [Y_W-1:0] y,
                                                     input logic [X_W-1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Bundle of display, writer, clear-control and BRAM port signals around the arbiter.
// slave = arbiter side, master = user/BRAM side.
interface bram_port_arbiter_if;
    import bram_pkg::*;

    logic              disp_active;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              wr_ack;
    logic              clear_start;
    logic              clear_busy;
    logic              clear_done;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_din;
    logic              bram_we;
    logic              bram_dout;

    modport slave (
        input  disp_active, disp_addr, wr_req, wr_addr, wr_data, clear_start, bram_dout,
        output disp_data, wr_ack, clear_busy, clear_done, bram_addr, bram_din, bram_we
    );

    modport master (
        output disp_active, disp_addr, wr_req, wr_addr, wr_data, clear_start, bram_dout,
        input  disp_data, wr_ack, clear_busy, clear_done, bram_addr, bram_din, bram_we
    );

endinterface

// File: rtl/bram_clear_sweeper.sv
// Raster x/y counter for the frame-clear sweep: advances on adv_i, wraps x into y,
// flags the final pixel and returns to {0,0} after it.
module bram_clear_sweeper
    import bram_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DFLT,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam logic [X_W-1:0] XLast = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] YLast = Y_W'(V_ACTIVE - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           x_end;

    assign x_end  = (x_q == XLast);
    assign last_o = x_end && (y_q == YLast);
    assign addr_o = pack_addr(y_q, x_q);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (adv_i) begin
            if (x_end) begin
                x_d = '0;
                y_d = last_o ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Single-port frame BRAM arbiter: display reads win outright, a one-entry buffered pixel
// writer and (with BRAM_ARB_CLEAR_EN defined) a full-frame clear sweep share blanking cycles.
module bram_port_arbiter
    import bram_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DFLT,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DFLT,
    parameter logic        CLEAR_VALUE = 1'b0
) (
    input logic                clk,
    input logic                reset,
    bram_port_arbiter_if.slave bus
);

    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic              buf_data_q, buf_data_d;
    logic              wr_ack_q, wr_ack_d;
    logic              drain, buf_free, accept;
    logic              in_idle, clear_go, sweep_we;
    logic [ADDR_W-1:0] sweep_addr;

    assign drain    = !bus.disp_active && buf_valid_q;
    assign buf_free = !buf_valid_q || drain;

`ifdef BRAM_ARB_CLEAR_EN
    arb_state_e state_q, state_d;
    logic       clear_done_q, clear_done_d;
    logic       sweep_last;

    assign in_idle  = (state_q == StIdle);
    assign clear_go = in_idle && bus.clear_start;
    // Sweep waits behind a buffered pixel so the clear overwrites it.
    assign sweep_we = (state_q == StClear) && !bus.disp_active && !buf_valid_q;

    bram_clear_sweeper #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE)
    ) u_sweeper (
        .clk   (clk),
        .reset (reset),
        .adv_i (sweep_we),
        .addr_o(sweep_addr),
        .last_o(sweep_last)
    );

    always_comb begin
        state_d      = state_q;
        clear_done_d = 1'b0;
        unique case (state_q)
            StIdle:  if (bus.clear_start) state_d = StClear;
            StClear: begin
                if (sweep_we && sweep_last) begin
                    state_d      = StIdle;
                    clear_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign bus.clear_busy = (state_q == StClear);
    assign bus.clear_done = clear_done_q;
`else
    assign in_idle        = 1'b1;
    assign clear_go       = 1'b0;
    assign sweep_we       = 1'b0;
    assign sweep_addr     = '0;
    assign bus.clear_busy = 1'b0;
    assign bus.clear_done = 1'b0;
`endif

    // A capture and a drain in the same cycle keep the buffer full back-to-back.
    assign accept = bus.wr_req && buf_free && in_idle && !clear_go;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        wr_ack_d    = accept;
        if (drain) buf_valid_d = 1'b0;
        if (accept) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = bus.wr_addr;
            buf_data_d  = bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= 1'b0;
            wr_ack_q    <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            wr_ack_q    <= wr_ack_d;
        end
    end

    always_comb begin
        bus.bram_addr = bus.disp_addr;
        bus.bram_din  = 1'b0;
        bus.bram_we   = 1'b0;
        if (!bus.disp_active) begin
            if (buf_valid_q) begin
                bus.bram_addr = buf_addr_q;
                bus.bram_din  = buf_data_q;
                bus.bram_we   = 1'b1;
            end else if (sweep_we) begin
                bus.bram_addr = sweep_addr;
                bus.bram_din  = CLEAR_VALUE;
                bus.bram_we   = 1'b1;
            end
        end
    end

    assign bus.wr_ack    = wr_ack_q;
    assign bus.disp_data = bus.bram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter on a reduced 8x4 frame; clear-sweep scenarios
// are exercised when BRAM_ARB_CLEAR_EN is defined, clear_start inertness otherwise.
module tb_bram_port_arbiter;
    import bram_pkg::*;

    localparam int unsigned H = 8;
    localparam int unsigned V = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              din;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    bram_port_arbiter_if bus ();

    bram_port_arbiter #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .CLEAR_VALUE(1'b0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  ack_cnt = 0;
    int  done_cnt = 0;
    int  cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every BRAM write must match the head of the expected-write queue.
    always @(negedge clk) begin
        wr_t e;
        if (!reset) begin
            if (bus.wr_ack) ack_cnt++;
            if (bus.clear_done) done_cnt++;
            if (bus.bram_we) begin
                check("write_expected", 32'(exp_q.size() != 0), 1);
                check("write_in_blanking", 32'(bus.disp_active), 0);
                check("write_x_in_range", 32'(bus.bram_addr[X_W-1:0] < X_W'(H)), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(bus.bram_addr), 32'(e.addr));
                    check("write_data", 32'(bus.bram_din), 32'(e.din));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [Y_W-1:0] y, input logic [X_W-1:0] x, input logic d);
        wr_t e;
        e.addr = {y, x};
        e.din  = d;
        exp_q.push_back(e);
    endtask

    task automatic push_sweep();
        for (int y = 0; y < int'(V); y++)
            for (int x = 0; x < int'(H); x++) push_wr(Y_W'(y), X_W'(x), 1'b0);
    endtask

    task automatic wait_ack(input string name);
        int i;
        for (i = 0; i < 100; i++) begin
            tick();
            if (bus.wr_ack) break;
        end
        check({name, "_ack_in_time"}, 32'(i < 100), 1);
    endtask

    // Waits for clear_done; optionally re-pulses clear_start mid-sweep and/or toggles display.
    task automatic wait_done(input string name, input int poke_at, input bit toggle_disp);
        int i;
        for (i = 0; i < 2000; i++) begin
            tick();
            bus.clear_start = (i == poke_at);
            if (toggle_disp) bus.disp_active = (i % 3 == 1);
            if (bus.clear_done) break;
        end
        bus.clear_start = 1'b0;
        bus.disp_active = 1'b0;
        check({name, "_done_in_time"}, 32'(i < 2000), 1);
    endtask

    initial begin
        int ack_base, done_base, t_done, t_prev, t_ack;
        int i;
        logic [Y_W-1:0] by [4];
        logic [X_W-1:0] bx [4];
        logic           bd [4];
        by = '{9'd2, 9'd2, 9'd2, 9'd3};
        bx = '{10'd0, 10'd1, 10'd2, 10'd7};
        bd = '{1'b1, 1'b0, 1'b1, 1'b1};

        bus.disp_active = 1'b0;
        bus.disp_addr   = '0;
        bus.wr_req      = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = 1'b0;
        bus.clear_start = 1'b0;
        bus.bram_dout   = 1'b0;

        // Reset state
        #12;
        check("rst_bram_we", 32'(bus.bram_we), 0);
        check("rst_bram_din", 32'(bus.bram_din), 0);
        check("rst_wr_ack", 32'(bus.wr_ack), 0);
        check("rst_clear_busy", 32'(bus.clear_busy), 0);
        check("rst_clear_done", 32'(bus.clear_done), 0);
        tick();
        reset = 1'b0;
        tick();

        // Display path: read data passthrough and address mux
        bus.bram_dout = 1'b1;
        #1 check("disp_data_1", 32'(bus.disp_data), 1);
        bus.bram_dout = 1'b0;
        #1 check("disp_data_0", 32'(bus.disp_data), 0);
        bus.disp_active = 1'b1;
        bus.disp_addr   = 19'h12345;
        #1 check("disp_addr_mux", 32'(bus.bram_addr), 32'h12345);
        check("disp_no_we", 32'(bus.bram_we), 0);

        // Display priority: pixel waits in the buffer until blanking
        ack_base = ack_cnt;
        tick();
        bus.wr_req  = 1'b1;
        bus.wr_addr = 19'h00005;
        bus.wr_data = 1'b1;
        push_wr(9'd0, 10'd5, 1'b1);
        wait_ack("prio");
        bus.wr_req = 1'b0;
        for (i = 0; i < 3; i++) begin
            tick();
            check("prio_held", 32'(bus.bram_we), 0);
        end
        bus.disp_active = 1'b0;
        #1 check("prio_we", 32'(bus.bram_we), 1);
        check("prio_addr", 32'(bus.bram_addr), 32'h00005);
        tick();
        check("prio_drained", 32'(bus.bram_we), 0);
        check("prio_one_ack", 32'(ack_cnt - ack_base), 1);
        check("prio_queue_empty", 32'(exp_q.size()), 0);

        // Back-to-back writes in blanking
        ack_base = ack_cnt;
        for (int k = 0; k < 4; k++) push_wr(by[k], bx[k], bd[k]);
        bus.wr_req  = 1'b1;
        bus.wr_addr = {by[0], bx[0]};
        bus.wr_data = bd[0];
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack("b2b");
            if (k > 0) check("b2b_consecutive_ack", 32'(cyc - t_prev), 1);
            t_prev = cyc;
            if (k < 3) begin
                bus.wr_addr = {by[k+1], bx[k+1]};
                bus.wr_data = bd[k+1];
            end else begin
                bus.wr_req = 1'b0;
            end
        end
        tick();
        tick();
        check("b2b_ack_count", 32'(ack_cnt - ack_base), 4);
        check("b2b_queue_empty", 32'(exp_q.size()), 0);

        // Async reset while a pixel is draining and an ack is showing
        bus.disp_active = 1'b1;
        bus.wr_req      = 1'b1;
        bus.wr_addr     = {9'd1, 10'd1};
        bus.wr_data     = 1'b1;
        wait_ack("rst_mid");
        bus.wr_req      = 1'b0;
        bus.disp_active = 1'b0;
        #1 reset = 1'b1;
        #1 check("rst_mid_we", 32'(bus.bram_we), 0);
        check("rst_mid_ack", 32'(bus.wr_ack), 0);
        check("rst_mid_busy", 32'(bus.clear_busy), 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("rst_mid_no_write", 32'(bus.bram_we), 0);
        check("rst_mid_queue_empty", 32'(exp_q.size()), 0);

`ifdef BRAM_ARB_CLEAR_EN
        // Full sweep with a clear_start pulse mid-sweep that must be ignored
        done_base = done_cnt;
        push_sweep();
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        check("sweep_busy", 32'(bus.clear_busy), 1);
        wait_done("sweep", 10, 1'b0);
        check("sweep_busy_fell", 32'(bus.clear_busy), 0);
        tick();
        check("sweep_one_done", 32'(done_cnt - done_base), 1);
        check("sweep_queue_empty", 32'(exp_q.size()), 0);

        // Buffered pixel + clear_start together; request held across the sweep
        bus.disp_active = 1'b1;
        bus.wr_req      = 1'b1;
        bus.wr_addr     = {9'd1, 10'd3};
        bus.wr_data     = 1'b1;
        push_wr(9'd1, 10'd3, 1'b1);
        wait_ack("bufclr");
        bus.wr_req      = 1'b0;
        bus.clear_start = 1'b1;
        push_sweep();
        tick();
        bus.clear_start = 1'b0;
        check("bufclr_busy", 32'(bus.clear_busy), 1);
        bus.wr_req  = 1'b1;
        bus.wr_addr = {9'd2, 10'd6};
        bus.wr_data = 1'b1;
        push_wr(9'd2, 10'd6, 1'b1);
        ack_base = ack_cnt;
        wait_done("bufclr", -1, 1'b1);
        t_done = cyc;
        check("bufclr_no_ack_in_clear", 32'(ack_cnt - ack_base), 0);
        wait_ack("bufclr_held");
        t_ack = cyc;
        bus.wr_req = 1'b0;
        check("bufclr_ack_after_done", 32'(t_ack - t_done), 1);
        tick();
        tick();
        check("bufclr_queue_empty", 32'(exp_q.size()), 0);

        // Reset mid-sweep, then a fresh sweep restarts at {0,0}
        done_base = done_cnt;
        for (int x = 0; x < int'(H); x++) push_wr(9'd0, X_W'(x), 1'b0);
        push_wr(9'd1, 10'd0, 1'b0);
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("abort_reached_y1", 32'(i < 200), 1);
        tick();
        reset = 1'b1;
        #1 check("abort_busy", 32'(bus.clear_busy), 0);
        check("abort_we", 32'(bus.bram_we), 0);
        tick();
        reset = 1'b0;
        for (i = 0; i < 5; i++) tick();
        check("abort_no_done", 32'(done_cnt - done_base), 0);
        check("abort_idle", 32'(bus.clear_busy), 0);
        push_sweep();
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        wait_done("restart", -1, 1'b0);
        tick();
        check("restart_one_done", 32'(done_cnt - done_base), 1);
        check("restart_queue_empty", 32'(exp_q.size()), 0);
`else
        // Clear engine absent: clear_start must be inert
        done_base = done_cnt;
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        check("noclr_busy", 32'(bus.clear_busy), 0);
        for (i = 0; i < 4; i++) begin
            tick();
            check("noclr_no_we", 32'(bus.bram_we), 0);
        end
        check("noclr_no_done", 32'(done_cnt - done_base), 0);
        check("noclr_queue_empty", 32'(exp_q.size()), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
